rv_test_monitor: RTL and testbench
==================================

# rv_test_monitor

Parametrised test-completion and trace monitor for Verilator simulation of the pipelined RV core. It sits beside the core in the simulation wrapper and observes the core's `pc_out`/`instr_out` pair. It counts cycles and retired instructions, recognises 16-bit compressed encodings, and detects test end: ECALL pass, EBREAK/C.EBREAK fail, PC hang, or timeout. Retired instructions are buffered in a trace FIFO that the C++ harness drains with a valid/ready handshake.

## Interface
- `XLEN`, 32: width of PC and instruction buses.
- `CNT_WIDTH`, 32: width of the cycle and instruction counters; must satisfy TIMEOUT < 2^CNT_WIDTH.
- `TIMEOUT`, 100000: RUN cycles before a timeout is declared.
- `STALL_LIMIT`, 8: consecutive RUN cycles without a retire that declare a hang; must be ≥2.
- `TRACE_DEPTH`, 16: trace FIFO entries; must be a power of 2 and ≥2.

Ports:
- `clk`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  start monitoring; sampled only in IDLE.
- `pc_in`  in  XLEN  core PC (`pc_out` of the core).
- `instr_in`  in  32  core instruction (`instr_out` of the core).
- `done`  out  1  test finished; sticky.
- `exit_code`  out  3  0 running, 1 pass, 2 fail, 3 hang, 4 timeout.
- `cycle_count`  out  CNT_WIDTH  RUN cycles elapsed.
- `instr_count`  out  CNT_WIDTH  retires observed.
- `trace_valid`  out  1  FIFO non-empty.
- `trace_ready`  in  1  harness pops the head entry.
- `trace_pc`  out  XLEN  PC of the head entry.
- `trace_instr`  out  32  instruction of the head entry; upper 16 bits are zeroed when compressed.
- `trace_rvc`  out  1  head entry is a compressed instruction.
- `trace_overflow`  out  1  sticky; at least one retire was dropped.

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE.
- IDLE→RUN when `enable`=1. RUN→DONE on any end event. DONE is left only by reset.
- Retire event: state RUN and (`pc_seen`=0 or `pc_in`≠`pc_prev`).
  - On every RUN cycle, `pc_prev`←`pc_in` and `pc_seen`←1.
  - Consequence: the first RUN cycle always retires.
- Compressed: `instr_in[1:0]`≠2'b11.
- End events are evaluated only on retire cycles, except hang and timeout.
  - pass: a 32-bit instruction equal to 32'h00000073 (ECALL).
  - fail: a 32-bit instruction equal to 32'h00100073 (EBREAK), or a compressed instruction whose `instr_in[15:0]`=16'h9002 (C.EBREAK).
  - hang: the stall counter reaches STALL_LIMIT. The stall counter increments on each RUN cycle without a retire, clears on a retire, and saturates.
  - timeout: `cycle_count` reaches TIMEOUT.
- Priority for simultaneous events: pass/fail > hang > timeout.
- The terminating retire is counted in `instr_count` and pushed to the trace FIFO.
- FIFO push on every retire in RUN; no pushes in IDLE or DONE.
  - Full with no pop in the same cycle: the entry is dropped, `trace_overflow`←1, and `instr_count` still increments.
  - Full with a pop in the same cycle: push and pop both occur; no overflow.
  - Empty with a push: the entry becomes visible on the next cycle. There is no fall-through.
- Pops continue in DONE until the FIFO is empty.
- Pointers wrap modulo TRACE_DEPTH. An extra occupancy bit distinguishes full from empty.

## Timing
- Reset values of all outputs: `done`=0, `exit_code`=0, counters 0, `trace_valid`=0, `trace_overflow`=0, trace data 0. FIFO pointers, `pc_prev`, `pc_seen` and the stall counter also clear.
- Reset asserted mid-run immediately clears all state and returns to IDLE. Any FIFO contents are discarded.
- `cycle_count` increments once per RUN cycle, including the cycle that triggers DONE. It freezes in DONE.
- End detection latency is one cycle: the event is seen in cycle N, and `done`/`exit_code` are valid from cycle N+1 onward.
- Trace data is registered; `trace_*` outputs are stable while `trace_valid`=1 and `trace_ready`=0.
- Pop occurs on a rising edge where `trace_valid`=1 and `trace_ready`=1. `trace_ready` when empty has no effect.

## Test plan
- Reset, `enable`=1. Drive PCs 0,4,8,12, then ECALL at PC 16 → `done`=1 and `exit_code`=1 one cycle later. `instr_count`=5, `cycle_count`=5, and the trace holds five entries in order.
- Drive a compressed `instr_in`=32'h00009002 at PC 6 → `exit_code`=2, `trace_rvc`=1, `trace_instr`=32'h00009002. Also drive 32'h00100073 → `exit_code`=2.
- Hold `pc_in`=0x20 constant with STALL_LIMIT=8 → one retire, then `done` with `exit_code`=3 after 8 more cycles; `cycle_count`=9.
- Use TIMEOUT=50 with a PC changing every cycle and `trace_ready`=1 → `exit_code`=4 and `cycle_count`=50. Retiring ECALL on cycle 50 instead → `exit_code`=1.
- Use TRACE_DEPTH=4 with `trace_ready`=0 and six retires → `trace_overflow`=1, four entries kept in order, `instr_count`=6. A simultaneous push and pop while full → no overflow.
- Assert `reset_n` low during RUN with a full FIFO → all outputs at reset values on the same cycle. Hold `enable`=0 → counters stay at 0.

Source files
------------

// File: rtl/rv_test_monitor_if.sv
// Trace drain channel between the test monitor and the simulation harness.
// The monitor (master) presents the head trace entry; the harness (slave)
// acknowledges with trace_ready to pop it.
interface rv_test_monitor_if #(
  parameter int XLEN = 32
);
  logic            trace_valid;
  logic            trace_ready;
  logic [XLEN-1:0] trace_pc;
  logic [31:0]     trace_instr;
  logic            trace_rvc;

  modport master (
    output trace_valid,
    output trace_pc,
    output trace_instr,
    output trace_rvc,
    input  trace_ready
  );

  modport slave (
    input  trace_valid,
    input  trace_pc,
    input  trace_instr,
    input  trace_rvc,
    output trace_ready
  );
endinterface

// File: rtl/rv_test_monitor.sv
// Test-completion and trace monitor for the pipelined RV core.
// Watches the core's PC/instruction pair, counts cycles and retires, detects
// ECALL pass, EBREAK/C.EBREAK fail, PC hang and timeout, and buffers every
// retired instruction in a trace FIFO drained by the harness.
module rv_test_monitor #(
  parameter int XLEN        = 32,
  parameter int CNT_WIDTH   = 32,
  parameter int TIMEOUT     = 100000,
  parameter int STALL_LIMIT = 8,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [XLEN-1:0]      pc_in,
  input  logic [31:0]          instr_in,
  output logic                 done,
  output logic [2:0]           exit_code,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic                 trace_overflow,
  rv_test_monitor_if.master    trace
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] EcallInstr  = 32'h0000_0073;
  localparam logic [31:0] EbreakInstr = 32'h0010_0073;
  localparam logic [15:0] CEbreak     = 16'h9002;

  localparam logic [2:0] ExitPass    = 3'd1;
  localparam logic [2:0] ExitFail    = 3'd2;
  localparam logic [2:0] ExitHang    = 3'd3;
  localparam logic [2:0] ExitTimeout = 3'd4;

  // The event fires in the cycle whose increment would reach the limit, so
  // the limit value itself is what ends up visible in the counters.
  localparam int                   StallW      = $clog2(STALL_LIMIT + 1);
  localparam logic [StallW-1:0]    StallLast   = StallW'(STALL_LIMIT - 1);
  localparam logic [StallW-1:0]    StallMax    = StallW'(STALL_LIMIT);
  localparam logic [CNT_WIDTH-1:0] TimeoutLast = CNT_WIDTH'(TIMEOUT - 1);

  localparam int AW = $clog2(TRACE_DEPTH);

  state_e                state_q, state_d;
  logic [2:0]            exitCode_q, exitCode_d;
  logic [CNT_WIDTH-1:0]  cycleCount_q;
  logic [CNT_WIDTH-1:0]  instrCount_q;
  logic [StallW-1:0]     stallCnt_q;
  logic [XLEN-1:0]       pcPrev_q;
  logic                  pcSeen_q;
  logic                  overflow_q;

  logic [AW:0]           wrPtr_q;
  logic [AW:0]           rdPtr_q;
  logic [XLEN-1:0]       memPc    [TRACE_DEPTH];
  logic [31:0]           memInstr [TRACE_DEPTH];
  logic                  memRvc   [TRACE_DEPTH];

  logic running;
  logic isRvc;
  logic retire;
  logic passEvt;
  logic failEvt;
  logic hangEvt;
  logic timeoutEvt;
  logic fifoEmpty;
  logic fifoFull;
  logic doPop;
  logic doPush;
  logic dropEntry;
  logic [31:0] storedInstr;

  assign running     = (state_q == RUN);
  assign isRvc       = (instr_in[1:0] != 2'b11);
  assign retire      = running && (!pcSeen_q || (pc_in != pcPrev_q));
  assign passEvt     = retire && !isRvc && (instr_in == EcallInstr);
  assign failEvt     = retire && ((!isRvc && (instr_in == EbreakInstr)) ||
                                  (isRvc && (instr_in[15:0] == CEbreak)));
  assign hangEvt     = running && !retire && (stallCnt_q == StallLast);
  assign timeoutEvt  = running && (cycleCount_q == TimeoutLast);

  assign fifoEmpty   = (wrPtr_q == rdPtr_q);
  assign fifoFull    = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                       (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign doPop       = !fifoEmpty && trace.trace_ready;
  assign doPush      = retire && (!fifoFull || doPop);
  assign dropEntry   = retire && fifoFull && !doPop;
  assign storedInstr = isRvc ? {16'h0000, instr_in[15:0]} : instr_in;

  // FSM state register together with the latched exit code
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      exitCode_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      exitCode_q <= exitCode_d;
    end
  end

  // FSM next state: start on enable, stop on the highest-priority end event
  always_comb begin
    state_d    = state_q;
    exitCode_d = exitCode_q;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (passEvt) begin
          state_d    = DONE;
          exitCode_d = ExitPass;
        end else if (failEvt) begin
          state_d    = DONE;
          exitCode_d = ExitFail;
        end else if (hangEvt) begin
          state_d    = DONE;
          exitCode_d = ExitHang;
        end else if (timeoutEvt) begin
          state_d    = DONE;
          exitCode_d = ExitTimeout;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs and the registered trace head presented to the harness
  always_comb begin
    done              = (state_q == DONE);
    exit_code         = exitCode_q;
    cycle_count       = cycleCount_q;
    instr_count       = instrCount_q;
    trace_overflow    = overflow_q;
    trace.trace_valid = !fifoEmpty;
    trace.trace_pc    = '0;
    trace.trace_instr = '0;
    trace.trace_rvc   = 1'b0;
    if (!fifoEmpty) begin
      trace.trace_pc    = memPc[rdPtr_q[AW-1:0]];
      trace.trace_instr = memInstr[rdPtr_q[AW-1:0]];
      trace.trace_rvc   = memRvc[rdPtr_q[AW-1:0]];
    end
  end

  // Cycle/retire counters, PC history and saturating stall counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycleCount_q <= '0;
      instrCount_q <= '0;
      stallCnt_q   <= '0;
      pcPrev_q     <= '0;
      pcSeen_q     <= 1'b0;
    end else if (running) begin
      cycleCount_q <= cycleCount_q + 1'b1;
      pcPrev_q     <= pc_in;
      pcSeen_q     <= 1'b1;
      if (retire) begin
        instrCount_q <= instrCount_q + 1'b1;
        stallCnt_q   <= '0;
      end else if (stallCnt_q != StallMax) begin
        stallCnt_q <= stallCnt_q + 1'b1;
      end
    end
  end

  // Trace FIFO pointers and sticky overflow flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop) rdPtr_q <= rdPtr_q + 1'b1;
      if (dropEntry) overflow_q <= 1'b1;
    end
  end

  // Trace FIFO storage; stale contents are masked by the empty check
  always_ff @(posedge clk) begin
    if (doPush) begin
      memPc[wrPtr_q[AW-1:0]]    <= pc_in;
      memInstr[wrPtr_q[AW-1:0]] <= storedInstr;
      memRvc[wrPtr_q[AW-1:0]]   <= isRvc;
    end
  end

endmodule

// File: tb/tb_rv_test_monitor.sv
// Directed self-checking bench for rv_test_monitor. Two instances share the
// core-side stimulus: a 16-deep one for end-event checks and a 4-deep one for
// FIFO overflow and reset checks.
module tb_rv_test_monitor;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] pc_in = 32'h0;
  logic [31:0] instr_in = NOP;

  logic        doneA, doneB;
  logic [2:0]  exitA, exitB;
  logic [31:0] cycA, cycB, insA, insB;
  logic        ovfA, ovfB;

  int errorCount = 0;
  int checkCount = 0;

  rv_test_monitor_if #(.XLEN(32)) mainIf ();
  rv_test_monitor_if #(.XLEN(32)) smallIf ();

  rv_test_monitor #(
    .XLEN(32), .CNT_WIDTH(32), .TIMEOUT(50), .STALL_LIMIT(8), .TRACE_DEPTH(16)
  ) dutMain (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .pc_in(pc_in), .instr_in(instr_in),
    .done(doneA), .exit_code(exitA),
    .cycle_count(cycA), .instr_count(insA),
    .trace_overflow(ovfA), .trace(mainIf)
  );

  rv_test_monitor #(
    .XLEN(32), .CNT_WIDTH(32), .TIMEOUT(50), .STALL_LIMIT(8), .TRACE_DEPTH(4)
  ) dutSmall (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .pc_in(pc_in), .instr_in(instr_in),
    .done(doneB), .exit_code(exitB),
    .cycle_count(cycB), .instr_count(insB),
    .trace_overflow(ovfB), .trace(smallIf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr);
    pc_in    = pc;
    instr_in = instr;
    tick();
  endtask

  task automatic resetDut();
    reset_n = 1'b0;
    enable  = 1'b0;
    mainIf.trace_ready  = 1'b0;
    smallIf.trace_ready = 1'b0;
    pc_in    = 32'h0;
    instr_in = NOP;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic startRun();
    enable = 1'b1;
    tick();
  endtask

  initial begin
    mainIf.trace_ready  = 1'b0;
    smallIf.trace_ready = 1'b0;

    // Reset values
    resetDut();
    checkOutput("rst_done", 64'(doneA), 64'd0);
    checkOutput("rst_exit", 64'(exitA), 64'd0);
    checkOutput("rst_cycle", 64'(cycA), 64'd0);
    checkOutput("rst_instr", 64'(insA), 64'd0);
    checkOutput("rst_valid", 64'(mainIf.trace_valid), 64'd0);
    checkOutput("rst_ovf", 64'(ovfA), 64'd0);

    // Idle with enable low: nothing counts
    applyStimulus(32'h0, NOP);
    applyStimulus(32'h4, NOP);
    checkOutput("idle_cycle", 64'(cycA), 64'd0);
    checkOutput("idle_valid", 64'(mainIf.trace_valid), 64'd0);

    // ECALL pass after four ordinary retires
    startRun();
    applyStimulus(32'h0, NOP);
    applyStimulus(32'h4, NOP);
    applyStimulus(32'h8, NOP);
    applyStimulus(32'hC, NOP);
    checkOutput("pass_done_early", 64'(doneA), 64'd0);
    applyStimulus(32'h10, ECALL);
    checkOutput("pass_done", 64'(doneA), 64'd1);
    checkOutput("pass_exit", 64'(exitA), 64'd1);
    checkOutput("pass_instr", 64'(insA), 64'd5);
    checkOutput("pass_cycle", 64'(cycA), 64'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput("pass_trace_valid", 64'(mainIf.trace_valid), 64'd1);
      checkOutput("pass_trace_pc", 64'(mainIf.trace_pc), 64'(i * 4));
      checkOutput("pass_trace_instr", 64'(mainIf.trace_instr), (i == 4) ? 64'(ECALL) : 64'(NOP));
      mainIf.trace_ready = 1'b1;
      tick();
      mainIf.trace_ready = 1'b0;
    end
    checkOutput("pass_trace_empty", 64'(mainIf.trace_valid), 64'd0);
    checkOutput("pass_cycle_frozen", 64'(cycA), 64'd5);

    // C.EBREAK fail, with a compressed NOP carrying junk upper bits before it
    resetDut();
    startRun();
    applyStimulus(32'h0, NOP);
    applyStimulus(32'h4, 32'hFFFF_0001);
    applyStimulus(32'h6, 32'h0000_9002);
    checkOutput("cebrk_done", 64'(doneA), 64'd1);
    checkOutput("cebrk_exit", 64'(exitA), 64'd2);
    checkOutput("cebrk_instr", 64'(insA), 64'd3);
    checkOutput("cebrk_head_rvc", 64'(mainIf.trace_rvc), 64'd0);
    mainIf.trace_ready = 1'b1;
    tick();
    checkOutput("cnop_trace_instr", 64'(mainIf.trace_instr), 64'h0000_0001);
    checkOutput("cnop_trace_rvc", 64'(mainIf.trace_rvc), 64'd1);
    tick();
    mainIf.trace_ready = 1'b0;
    checkOutput("cebrk_trace_pc", 64'(mainIf.trace_pc), 64'h6);
    checkOutput("cebrk_trace_instr", 64'(mainIf.trace_instr), 64'h0000_9002);
    checkOutput("cebrk_trace_rvc", 64'(mainIf.trace_rvc), 64'd1);

    // 32-bit EBREAK fail on the very first retire
    resetDut();
    startRun();
    applyStimulus(32'h0, EBREAK);
    checkOutput("ebrk_exit", 64'(exitA), 64'd2);
    checkOutput("ebrk_cycle", 64'(cycA), 64'd1);

    // Hang: one retire then eight stalled cycles
    resetDut();
    startRun();
    repeat (8) applyStimulus(32'h20, NOP);
    checkOutput("hang_done_early", 64'(doneA), 64'd0);
    applyStimulus(32'h20, NOP);
    checkOutput("hang_done", 64'(doneA), 64'd1);
    checkOutput("hang_exit", 64'(exitA), 64'd3);
    checkOutput("hang_cycle", 64'(cycA), 64'd9);
    checkOutput("hang_instr", 64'(insA), 64'd1);

    // Timeout with a PC changing every cycle and the harness always ready
    resetDut();
    mainIf.trace_ready  = 1'b1;
    smallIf.trace_ready = 1'b1;
    startRun();
    for (int i = 0; i < 49; i++) applyStimulus(32'(i * 4), NOP);
    checkOutput("tmo_done_early", 64'(doneA), 64'd0);
    checkOutput("tmo_cycle_early", 64'(cycA), 64'd49);
    applyStimulus(32'd196, NOP);
    checkOutput("tmo_done", 64'(doneA), 64'd1);
    checkOutput("tmo_exit", 64'(exitA), 64'd4);
    checkOutput("tmo_cycle", 64'(cycA), 64'd50);
    repeat (3) applyStimulus(32'd300, NOP);
    checkOutput("tmo_cycle_frozen", 64'(cycA), 64'd50);
    checkOutput("tmo_ovf", 64'(ovfA), 64'd0);

    // ECALL retiring on the timeout cycle wins
    resetDut();
    mainIf.trace_ready = 1'b1;
    startRun();
    for (int i = 0; i < 49; i++) applyStimulus(32'(i * 4), NOP);
    applyStimulus(32'd196, ECALL);
    checkOutput("tmo_pass_exit", 64'(exitA), 64'd1);
    checkOutput("tmo_pass_cycle", 64'(cycA), 64'd50);
    checkOutput("tmo_pass_instr", 64'(insA), 64'd50);

    // Overflow on the 4-deep FIFO: six retires, no pops
    resetDut();
    startRun();
    for (int i = 0; i < 4; i++) applyStimulus(32'(i * 4), NOP);
    checkOutput("ovf_full_no_ovf", 64'(ovfB), 64'd0);
    applyStimulus(32'd16, NOP);
    checkOutput("ovf_set", 64'(ovfB), 64'd1);
    applyStimulus(32'd20, NOP);
    checkOutput("ovf_instr", 64'(insB), 64'd6);
    for (int i = 0; i < 4; i++) begin
      checkOutput("ovf_trace_pc", 64'(smallIf.trace_pc), 64'(i * 4));
      smallIf.trace_ready = 1'b1;
      tick();
      smallIf.trace_ready = 1'b0;
    end
    checkOutput("ovf_drained", 64'(smallIf.trace_valid), 64'd0);

    // Simultaneous push and pop while full: no overflow
    resetDut();
    startRun();
    for (int i = 0; i < 4; i++) applyStimulus(32'(i * 4), NOP);
    smallIf.trace_ready = 1'b1;
    applyStimulus(32'd16, NOP);
    smallIf.trace_ready = 1'b0;
    checkOutput("pp_ovf", 64'(ovfB), 64'd0);
    for (int i = 1; i < 5; i++) begin
      checkOutput("pp_trace_pc", 64'(smallIf.trace_pc), 64'(i * 4));
      smallIf.trace_ready = 1'b1;
      tick();
      smallIf.trace_ready = 1'b0;
    end
    checkOutput("pp_drained", 64'(smallIf.trace_valid), 64'd0);

    // Asynchronous reset in RUN with a full FIFO
    resetDut();
    startRun();
    for (int i = 0; i < 5; i++) applyStimulus(32'(i * 4), NOP);
    checkOutput("ar_pre_valid", 64'(smallIf.trace_valid), 64'd1);
    checkOutput("ar_pre_ovf", 64'(ovfB), 64'd1);
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    checkOutput("ar_done", 64'(doneB), 64'd0);
    checkOutput("ar_exit", 64'(exitB), 64'd0);
    checkOutput("ar_cycle", 64'(cycB), 64'd0);
    checkOutput("ar_instr", 64'(insB), 64'd0);
    checkOutput("ar_valid", 64'(smallIf.trace_valid), 64'd0);
    checkOutput("ar_ovf", 64'(ovfB), 64'd0);
    checkOutput("ar_trace_pc", 64'(smallIf.trace_pc), 64'd0);
    checkOutput("ar_trace_instr", 64'(smallIf.trace_instr), 64'd0);
    checkOutput("ar_trace_rvc", 64'(smallIf.trace_rvc), 64'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(32'(100 + i * 4), NOP);
    checkOutput("ar_idle_cycle", 64'(cycB), 64'd0);
    checkOutput("ar_idle_instr", 64'(insB), 64'd0);
    checkOutput("ar_idle_valid", 64'(smallIf.trace_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
